// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter on the MIPS data-memory
//               bus. Word stores to TXDATA are queued in a byte FIFO and
//               serialised LSB first on tx. STATUS exposes full, empty, busy,
//               sticky overflow and the FIFO count. Any write to CTRL clears
//               overflow.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-high reset
//               MemWrite   - store strobe
//               MemRead    - load strobe
//               Address    - byte address (ALU result)
//               WriteData  - store data, only [7:0] is used
//               ReadData   - combinational load data, 0 unless a STATUS load hits
//               Hit        - combinational window decode
//               tx         - registered serial output, idles high
// Register map: +0x0 TXDATA (W), +0x4 STATUS (R), +0x8 CTRL (W), +0xC reserved
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0020,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        tx
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0]        OFF_TXDATA = 2'd0;
    localparam logic [1:0]        OFF_STATUS = 2'd1;
    localparam logic [1:0]        OFF_CTRL   = 2'd2;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0] offset;
    logic       push_req;
    logic       ctrl_wr;
    logic       unused_ok;

    assign Hit      = (Address[31:4] == BASE_ADDR[31:4]);
    assign offset   = Address[3:2];
    assign push_req = Hit && MemWrite && (offset == OFF_TXDATA);
    assign ctrl_wr  = Hit && MemWrite && (offset == OFF_CTRL);

    // Byte lane inside the word and the upper store bits carry no meaning here.
    assign unused_ok = ^{Address[1:0], WriteData[31:8]};

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             overflow;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;
    logic             push_drop;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            // Setting wins over a same-cycle CTRL clear.
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (ctrl_wr) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              baud_done;
    logic              busy;

    assign baud_done = (baud_q == BAUD_LAST);
    assign busy      = (state_q != S_IDLE);
    assign tx        = tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, so tx changes on
    // the same edge as the state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr];
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data
    // ------------------------------------------------------------------
    logic [3:0] status_count;

    assign status_count = 4'(count);

    always_comb begin
        ReadData = '0;
        if (Hit && MemRead && (offset == OFF_STATUS)) begin
            ReadData = {24'h0, status_count, overflow, busy, empty, full};
        end
    end

endmodule
`default_nettype wire
